// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard direction decoder: FSM state
// encoding, scan-code set 2 control bytes and a helper to spot bytes that
// reset the parser.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Self-test pass and overrun/error bytes drop every held key.
  function automatic logic is_flush_code(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/prefix_timeout.sv
// Idle counter used to abandon a half-received prefix sequence. Clear wins
// over enable; done is asserted while the count sits at PREFIX_TIMEOUT-1.
module prefix_timeout #(
  parameter logic [19:0] PREFIX_TIMEOUT = 20'd50000
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);

  logic [19:0] cnt_q;
  logic [19:0] cnt_d;

  // Next count: restart on clear, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 20'd0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 20'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt_q <= 20'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == (PREFIX_TIMEOUT - 20'd1));

endmodule

// File: rtl/key_direction_decoder.sv
// Turns the PS/2 set-2 byte stream into held up/down commands for both rods.
// Make/break and E0 prefixes are tracked by a four-state FSM; each key has a
// held flag, and a rod asked to go both ways at once is told to go nowhere.
module key_direction_decoder
  import kbd_pkg::*;
#(
  parameter logic [7:0]  KEY_P1_UP      = 8'h1D,
  parameter logic [7:0]  KEY_P1_DOWN    = 8'h1B,
  parameter logic [7:0]  KEY_P2_UP      = 8'h75,
  parameter logic [7:0]  KEY_P2_DOWN    = 8'h72,
  parameter logic [19:0] PREFIX_TIMEOUT = 20'd50000
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       code_valid,
  input  logic [7:0] code_byte,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down
);

  kbd_state_e state_q, state_d;
  // held flags, bit order {h1u, h1d, h2u, h2d}
  logic [3:0] held_q, held_d;
  logic [3:0] out_q,  out_d;
  logic       timeout_done;

  prefix_timeout #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  ) u_prefix_timeout (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .clear_i (code_valid | (state_q == ST_IDLE)),
    .enable_i(state_q != ST_IDLE),
    .done_o  (timeout_done)
  );

  // Parse the incoming byte; a received byte takes precedence over timeout.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    if (code_valid) begin
      if (is_flush_code(code_byte)) begin
        held_d  = 4'b0000;
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (code_byte == PS2_EXT) begin
              state_d = ST_EXT;
            end else if (code_byte == PS2_BRK) begin
              state_d = ST_BRK;
            end else if (code_byte == KEY_P1_UP) begin
              held_d[3] = 1'b1;
            end else if (code_byte == KEY_P1_DOWN) begin
              held_d[2] = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_EXT: begin
            state_d = ST_IDLE;
            if (code_byte == PS2_BRK) begin
              state_d = ST_EXT_BRK;
            end else if (code_byte == PS2_EXT) begin
              state_d = ST_EXT;
            end else if (code_byte == KEY_P2_UP) begin
              held_d[1] = 1'b1;
            end else if (code_byte == KEY_P2_DOWN) begin
              held_d[0] = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_BRK: begin
            state_d = ST_IDLE;
            if (code_byte == PS2_BRK) begin
              state_d = ST_BRK;
            end else if (code_byte == KEY_P1_UP) begin
              held_d[3] = 1'b0;
            end else if (code_byte == KEY_P1_DOWN) begin
              held_d[2] = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            state_d = ST_IDLE;
            if (code_byte == KEY_P2_UP) begin
              held_d[1] = 1'b0;
            end else if (code_byte == KEY_P2_DOWN) begin
              held_d[0] = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end else if (timeout_done) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Output vector from next flags, with contradictory requests cancelled.
  always_comb begin
    out_d = {held_d[3] & ~held_d[2], held_d[2] & ~held_d[3],
             held_d[1] & ~held_d[0], held_d[0] & ~held_d[1]};
  end

  // State, flag and output registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      held_q  <= 4'b0000;
      out_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      out_q   <= out_d;
    end
  end

  assign p1_up   = out_q[3];
  assign p1_down = out_q[2];
  assign p2_up   = out_q[1];
  assign p2_down = out_q[0];

endmodule

// File: tb/tb_key_direction_decoder.sv
// Bench for key_direction_decoder: directed scenarios followed by random
// byte streams, all compared each cycle against a behavioural model.
module tb_key_direction_decoder;

  localparam logic [19:0] TO = 20'd24;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       code_valid;
  logic [7:0] code_byte;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic [3:0] dut_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one held bit per key plus "prefix seen" booleans.
  bit m_h1u, m_h1d, m_h2u, m_h2d;
  bit m_ext, m_brk;
  int m_idle;

  key_direction_decoder #(
    .PREFIX_TIMEOUT(TO)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .code_valid(code_valid),
    .code_byte (code_byte),
    .p1_up     (p1_up),
    .p1_down   (p1_down),
    .p2_up     (p2_up),
    .p2_down   (p2_down)
  );

  always #5 CLK = ~CLK;

  assign dut_out = {p1_up, p1_down, p2_up, p2_down};

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_out();
    return {m_h1u && !m_h1d, m_h1d && !m_h1u, m_h2u && !m_h2d, m_h2d && !m_h2u};
  endfunction

  task automatic m_reset();
    {m_h1u, m_h1d, m_h2u, m_h2d} = 4'b0000;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_idle = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
      {m_h1u, m_h1d, m_h2u, m_h2d} = 4'b0000;
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'h1D) m_h1u = 1'b1;
      else if (b == 8'h1B) m_h1d = 1'b1;
    end else if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b != 8'hE0) begin
        if (b == 8'h75) m_h2u = 1'b1;
        if (b == 8'h72) m_h2d = 1'b1;
        m_ext = 1'b0;
      end
    end else if (!m_ext && m_brk) begin
      if (b != 8'hF0) begin
        if (b == 8'h1D) m_h1u = 1'b0;
        if (b == 8'h1B) m_h1d = 1'b0;
        m_brk = 1'b0;
      end
    end else begin
      if (b == 8'h75) m_h2u = 1'b0;
      if (b == 8'h72) m_h2d = 1'b0;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  // One clock: drive, update model at the edge, compare 1 time unit later.
  task automatic cyc(input logic v, input logic [7:0] b, input string tag);
    code_valid = v;
    code_byte  = b;
    @(posedge CLK);
    if (v) begin
      m_byte(b);
      m_idle = 0;
    end else if (m_ext || m_brk) begin
      if (m_idle == int'(TO) - 1) begin
        m_ext = 1'b0; m_brk = 1'b0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    #1;
    check_eq(tag, dut_out, m_out());
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, "byte");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, "idle");
  endtask

  task automatic pulse_reset();
    code_valid = 1'b0;
    #2;
    RESETn = 1'b0;
    m_reset();
    #1;
    check_eq("async_reset", dut_out, 4'b0000);
    @(posedge CLK);
    #3;
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] tbl [10];
    tbl = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'hAA, 8'h00, 8'hFF, 8'h5A};
    if ($urandom_range(0, 99) < 8) return 8'($urandom);
    if ($urandom_range(0, 99) < 90) return tbl[$urandom_range(0, 5)];
    return tbl[$urandom_range(6, 9)];
  endfunction

  initial begin
    RESETn     = 1'b0;
    code_valid = 1'b0;
    code_byte  = 8'h00;
    m_reset();
    #12;
    check_eq("reset_state", dut_out, 4'b0000);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;

    // player 1 make / break
    send(8'h1D);                 check_eq("p1_up_make", dut_out, 4'b1000);
    send(8'hF0); send(8'h1D);    check_eq("p1_up_break", dut_out, 4'b0000);
    // player 2 extended make / break, plain 72 ignored
    send(8'hE0); send(8'h72);    check_eq("p2_down_make", dut_out, 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h72);
    check_eq("p2_down_break", dut_out, 4'b0000);
    send(8'h72);                 check_eq("plain_72", dut_out, 4'b0000);
    // contradiction suppression
    send(8'h1D); send(8'h1B);    check_eq("p1_both", dut_out, 4'b0000);
    send(8'hF0); send(8'h1D);    check_eq("p1_down_left", dut_out, 4'b0100);
    send(8'hF0); send(8'h1B);
    // timeout boundary: one clock short still parses the extension
    send(8'hE0); idle(int'(TO) - 1); send(8'h75);
    check_eq("to_edge_inside", dut_out, 4'b0010);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); idle(int'(TO)); send(8'h75);
    check_eq("to_expired", dut_out, 4'b0000);
    // typematic repeat then flush
    send(8'h1D); send(8'h1D); send(8'hE0); send(8'h75);
    check_eq("two_up", dut_out, 4'b1010);
    send(8'hAA);                 check_eq("flush_aa", dut_out, 4'b0000);
    send(8'h1D);                 check_eq("after_flush_idle", dut_out, 4'b1000);
    send(8'hFF);
    // reset mid-sequence
    send(8'hE0); send(8'h75); send(8'hE0);
    pulse_reset();
    send(8'hF0); send(8'h75);    check_eq("post_reset", dut_out, 4'b0000);

    // random streams
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 5) begin
        pulse_reset();
      end else if (r < 40) begin
        idle($urandom_range(int'(TO) - 2, int'(TO) + 2));
      end else if (r < 300) begin
        cyc(1'b0, 8'($urandom), "rand_gap");
      end else begin
        cyc(1'b1, pick_byte(), "rand_byte");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_direction_decoder.md
# key_direction_decoder

Converts the PS/2 scan-code set 2 byte stream from the keyboard front end into level-held direction commands for both foosball rods. Its outputs drive the `up_direction` and `down_direction` inputs of each player movement block, so it is the producing end of that interface. The block:

- tracks make/break and E0-extended prefixes with a small FSM;
- keeps one held flag per key;
- suppresses contradictory up+down requests.

## Interface
Parameters:
- KEY_P1_UP, 8'h1D, non-extended code for player 1 up (W)
- KEY_P1_DOWN, 8'h1B, non-extended code for player 1 down (S)
- KEY_P2_UP, 8'h75, E0-extended code for player 2 up (arrow up)
- KEY_P2_DOWN, 8'h72, E0-extended code for player 2 down (arrow down)
- PREFIX_TIMEOUT, 20'd50000, idle clocks after a prefix before the FSM abandons the sequence

Ports:
- CLK  input  1  system clock; the block uses this one clock only
- RESETn  input  1  asynchronous, active-low reset
- code_valid  input  1  one-cycle strobe: code_byte holds a new received byte
- code_byte  input  8  received scan-code byte
- p1_up  output  1  player 1 up held (registered)
- p1_down  output  1  player 1 down held (registered)
- p2_up  output  1  player 2 up held (registered)
- p2_down  output  1  player 2 down held (registered)

## Operation
- Held flags: h1u, h1d, h2u, h2d. Reset value 0.
- Output mapping (contradiction suppressed):
  - p1_up = h1u & ~h1d; p1_down = h1d & ~h1u.
  - p2_up and p2_down follow the same rule.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Reset state IDLE. Bytes with code_valid low are ignored.
- IDLE:
  - E0 -> EXT; F0 -> BRK.
  - KEY_P1_UP sets h1u; KEY_P1_DOWN sets h1d.
  - Any other byte: stay in IDLE, no flag change.
- EXT:
  - F0 -> EXT_BRK; E0 -> stay in EXT and restart the timeout.
  - KEY_P2_UP sets h2u; KEY_P2_DOWN sets h2d.
  - Any other byte -> IDLE, no flag change.
- BRK:
  - KEY_P1_UP clears h1u; KEY_P1_DOWN clears h1d.
  - F0 -> stay in BRK.
  - Anything else -> IDLE, no change.
  - Every non-F0 byte returns the FSM to IDLE.
- EXT_BRK:
  - KEY_P2_UP clears h2u; KEY_P2_DOWN clears h2d.
  - Then return to IDLE. Any other byte -> IDLE, no change.
- Extended codes are never matched in IDLE/BRK; non-extended codes are never matched in EXT/EXT_BRK.
- Special bytes, any state: 8'hAA (self-test pass), 8'h00 or 8'hFF (buffer overrun/error) clear all four flags and go to IDLE.
- Repeated make codes (typematic) re-set an already-set flag: harmless, no output change.
- Timeout:
  - A 20-bit counter runs in every non-IDLE state and is cleared on each accepted byte.
  - Reaching PREFIX_TIMEOUT-1 forces IDLE with no flag change.
  - In IDLE the counter holds at 0.

## Timing
- Latency: 1 clock. A byte sampled with code_valid at edge n updates the flags, state and outputs at that same edge, so the outputs are visible in cycle n+1.
- No handshake back to the source. Back-to-back code_valid cycles are legal and each byte is processed.
- Reset asserted mid-sequence: state IDLE, all outputs 0, counter 0 immediately (asynchronous). The first byte after release is parsed from IDLE.
- Outputs are glitch-free registers. The movement blocks sample them on their own timer tick, so no alignment to that tick is required here.

## Structure
- Shared package `kbd_pkg`:
  - enum typedef for the four FSM states;
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT_OK=8'hAA, PS2_ERR0=8'h00, PS2_ERR1=8'hFF.
- One sub-module, `prefix_timeout`:
  - counter with clear/enable inputs and a done output;
  - parameterized by PREFIX_TIMEOUT.
- The FSM and flag logic live in the top module.

## Test plan
- Byte 1D -> p1_up=1 next cycle. Then bytes F0,1D -> p1_up=0 one cycle after the 1D.
- Bytes E0,72 -> p2_down=1. Then E0,F0,72 -> p2_down=0. Plain 72 from IDLE -> no output change.
- 1D then 1B -> p1_up=0, p1_down=0. Then F0,1D -> p1_down=1.
- E0 alone, then no strobe for PREFIX_TIMEOUT clocks -> FSM back in IDLE. A following 75 with no new E0 -> p2_up stays 0.
- Flags h1u and h2u set, then byte AA -> all four outputs 0 next cycle, FSM in IDLE.
- Reset pulsed between E0 and F0 with p2_up=1 -> outputs 0 at once. The post-reset bytes F0,75 leave all outputs 0.
